// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   N-channel, W-bit streaming multiplexer with a single registered output
//   stage. Two run-time modes pick the source channel: direct select
//   (mode=0, `sel` names the channel) and round-robin arbitration (mode=1,
//   priority rotates past the most recently granted channel). The module
//   counts completed output handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = direct select, 1 = round-robin
//   sel        channel index used in mode 0 (values >= N never grant)
//   in_data    packed channel data, channel k at [k*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high (the granted channel)
//   out_data   registered data
//   out_chan   source channel of out_data
//   out_valid  output register holds data
//   out_ready  consumer accepts out_data
//   xfer_cnt   number of output handshakes, wraps at 2^CW
module rr_stream_mux #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int CW = 16,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     xfer_cnt
);

  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] last_q,      last_d;
  logic [CW-1:0] cnt_q,       cnt_d;

  logic          load_en;
  logic          dir_vld;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;
  logic          xfer_in;

  // The output register can take new data when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Direct select: comparing against every legal index excludes sel >= N
  // without an out-of-range bit select.
  always_comb begin
    dir_vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SW'(k) && in_valid[k]) dir_vld = 1'b1;
    end
  end

  // Round-robin: each channel's distance from the position after last_q is
  // (k - last_q - 1) mod N; the valid channel with the smallest distance
  // wins. Rewritten from a rotating scan so every bit select is constant.
  always_comb begin : rr_search
    int unsigned d;
    int unsigned best_d;
    d      = 0;
    best_d = N;
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      d = k + N - 32'(last_q) - 1;
      if (d >= N) d = d - N;
      if (in_valid[k] && d < best_d) begin
        best_d = d;
        rr_idx = SW'(k);
        rr_vld = 1'b1;
      end
    end
  end

  assign gnt_vld = mode ? rr_vld : dir_vld;
  assign gnt_idx = mode ? rr_idx : sel;
  assign xfer_in = gnt_vld && load_en;

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt_idx == SW'(k)) begin
        gnt_data    = in_data[k*W +: W];
        in_ready[k] = xfer_in;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if (load_en) begin
      if (xfer_in) begin
        out_data_d  = gnt_data;
        out_chan_d  = gnt_idx;
        out_valid_d = 1'b1;
        if (mode) last_d = gnt_idx;
      end else begin
        // Nothing to load: drop valid but keep the last data/channel visible.
        out_valid_d = 1'b0;
      end
    end
    if (out_valid_q && out_ready) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SW'(N - 1);
      cnt_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux
//   Bench for rr_stream_mux. The main instance (N=4, W=4, CW=16) is tracked
//   every cycle by a reference model whose predicted output items go through
//   a scoreboard queue; directed sequences add fixed expectations on top.
//   A second instance (N=3, CW=4) covers out-of-range select and counter wrap.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // main instance
  logic        mode, out_ready;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic [15:0] xfer_cnt;

  // N=3, CW=4 instance
  logic        mode2, out_ready2;
  logic [1:0]  sel2;
  logic [11:0] in_data2;
  logic [2:0]  in_valid2, in_ready2;
  logic [3:0]  out_data2;
  logic [1:0]  out_chan2;
  logic        out_valid2;
  logic [3:0]  xfer_cnt2;

  rr_stream_mux #(.N(4), .W(4), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt)
  );

  rr_stream_mux #(.N(3), .W(4), .CW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode2), .sel(sel2), .in_data(in_data2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
    .out_chan(out_chan2), .out_valid(out_valid2), .out_ready(out_ready2),
    .xfer_cnt(xfer_cnt2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard (main instance) ----------
  typedef struct packed {
    logic [3:0] data;
    logic [1:0] chan;
  } item_t;

  item_t       sb[$];
  logic        m_valid;
  int          m_last;
  logic [15:0] m_cnt;
  int          mg;
  int          c;
  logic [3:0]  exp_rdy;
  logic        m_load;

  // Sample mid-cycle; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_last  = 3;
      m_cnt   = '0;
      sb.delete();
    end else begin
      mg = -1;
      if (!mode) begin
        if (in_valid[sel]) mg = int'(sel);
      end else begin
        c = m_last;
        repeat (4) begin
          c = (c + 1) % 4;
          if (mg < 0 && in_valid[c]) mg = c;
        end
      end
      m_load  = !m_valid || out_ready;
      exp_rdy = (mg >= 0 && m_load) ? 4'(1 << mg) : 4'b0000;

      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, m_valid);
      check("xfer_cnt", xfer_cnt, m_cnt);
      if (m_valid) begin
        if (sb.size() == 0) check("sb_item", 0, 1);
        else begin
          check("out_data", out_data, sb[0].data);
          check("out_chan", out_chan, sb[0].chan);
        end
      end

      if (m_valid && out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (exp_rdy != 4'b0000) begin
        sb.push_back('{data: in_data[mg*4 +: 4], chan: 2'(mg)});
        m_valid = 1'b1;
        if (mode) m_last = mg;
      end else if (m_load) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mode      = 1'b0; sel  = '0; in_valid  = '0; in_data  = '0; out_ready  = 1'b0;
    mode2     = 1'b0; sel2 = '0; in_valid2 = '0; in_data2 = '0; out_ready2 = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_xfer_cnt",  xfer_cnt, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_chan",  out_chan, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // direct select
    do_reset();
    mode = 1'b0; sel = 2'd2; in_data = 16'h0A00; in_valid = 4'b0100; out_ready = 1'b1;
    @(negedge clk);
    check("t1_in_ready", in_ready, 4'b0100);
    tick();
    in_valid = 4'b0000;
    @(negedge clk);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 4'hA);
    check("t1_out_chan", out_chan, 2);
    tick();
    @(negedge clk);
    check("t1_xfer_cnt", xfer_cnt, 1);

    // round-robin, all channels valid
    do_reset();
    mode = 1'b1; in_data = 16'h9876; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      if (i == 7) begin
        #1;
        in_valid = 4'b0000;
      end
      @(negedge clk);
      check("t2_rr_chan", out_chan, i % 4);
    end
    @(negedge clk);
    check("t2_xfer_cnt", xfer_cnt, 8);

    // round-robin with stall
    do_reset();
    mode = 1'b1; in_data = 16'h5B3C; in_valid = 4'b1010; out_ready = 1'b0;
    @(negedge clk);
    check("t3_first_ready", in_ready, 4'b0010);
    repeat (3) begin
      tick();
      @(negedge clk);
      check("t3_hold_chan", out_chan, 1);
      check("t3_hold_ready", in_ready, 4'b0000);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ready", in_ready, 4'b1000);
    @(negedge clk);
    check("t3_next_chan3", out_chan, 3);
    @(negedge clk);
    check("t3_next_chan1", out_chan, 1);

    // direct select of an idle channel
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0001; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t4_no_ready", in_ready, 4'b0000);
      check("t4_no_valid", out_valid, 0);
    end

    // reset while stalled with last=2
    tick();
    do_reset();
    mode = 1'b1; in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("t5_pre_chan", out_chan, 2);
    check("t5_pre_valid", out_valid, 1);
    #2;
    do_reset();
    mode = 1'b1; in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    check("t5_post_ready", in_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("t5_post_chan", out_chan, 0);

    // mode switch keeps the round-robin pointer
    do_reset();
    mode = 1'b1; in_data = 16'hDCBA; in_valid = 4'b0011; out_ready = 1'b1;
    tick();
    tick();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    tick();
    mode = 1'b1; in_valid = 4'b1111;
    @(negedge clk);
    check("t6_sw_ready", in_ready, 4'b0100);
    tick();
    @(negedge clk);
    check("t6_sw_chan", out_chan, 2);

    // random traffic, checked by the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // N=3, CW=4 instance: counter wrap, then out-of-range select
    do_reset();
    mode2 = 1'b1; in_data2 = 12'h765; in_valid2 = 3'b111; out_ready2 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      if (i == 16) begin
        #1;
        in_valid2 = 3'b000;
      end
    end
    @(negedge clk);
    check("t7_cnt_16", xfer_cnt2, 0);
    @(negedge clk);
    check("t7_cnt_wrap", xfer_cnt2, 1);
    tick();
    mode2 = 1'b0; sel2 = 2'd3; in_valid2 = 3'b111;
    repeat (3) begin
      @(negedge clk);
      check("t8_sel3_ready", in_ready2, 3'b000);
      check("t8_sel3_valid", out_valid2, 0);
    end
    tick();
    sel2 = 2'd2;
    @(negedge clk);
    check("t8_sel2_ready", in_ready2, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
